// File: rtl/upconverter_pkg.sv
// Shared definitions for the upconverter: saturation limits for a signed
// sample of a given width, and the two mixer phases that alternate per
// output pair.
package upconverter_pkg;

  // Mixer phase selects which component of the output pair is negated.
  //   PH_POS_I : (I, -Qh)
  //   PH_NEG_I : (-I, Qh)
  typedef enum logic {
    PH_POS_I = 1'b0,
    PH_NEG_I = 1'b1
  } phase_e;

  // Largest positive value of a signed number of the given width (width <= 32).
  function automatic longint SAT_MAX(int unsigned width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  // Most negative value of a signed number of the given width (width <= 32).
  function automatic longint SAT_MIN(int unsigned width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/upconverter_skid.sv
// Two-entry skid buffer with a registered ready towards the producer.
//
// The output register is the main entry; the skid register catches the one
// beat that can arrive after the consumer stalls, because ready_o only drops
// on the following edge. Nothing offered while ready_o is high is lost.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   valid_i, ready_o   producer handshake (ready_o is a flop)
//   data_i             payload, 2*WIDTH bits
//   valid_o, ready_i   consumer handshake
//   data_o             payload presented to the consumer
module upconverter_skid #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [2*WIDTH-1:0] data_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [2*WIDTH-1:0] data_o
);

  logic               ready_q, ready_d;
  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] out_data_q, out_data_d;
  logic               skid_valid_q, skid_valid_d;
  logic [2*WIDTH-1:0] skid_data_q, skid_data_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = valid_i & ready_q;
  assign out_fire = out_valid_q & ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (!out_valid_q || out_fire) begin
      // Main entry is free this edge: refill from skid first to keep order.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_valid_d = 1'b1;
        out_data_d  = data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      // Consumer stalled while ready_o was still high: park the beat.
      skid_valid_d = 1'b1;
      skid_data_d  = data_i;
    end

    // Ready is simply "skid slot will be empty", so it is a pure flop output.
    ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      ready_q      <= ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = out_valid_q;
  assign data_o  = out_data_q;

endmodule

// File: rtl/upconverter.sv
// Interpolate-by-2 and fs/4 mixer producing a real sample pair per complex
// input sample.
//
// Each accepted sample x[n+1] closes the pair for x[n]: the half-sample
// point (Ih, Qh) is the rounded average of x[n] and x[n+1]. The pair is then
// mixed with a quarter-rate carrier, which at the output rate reduces to the
// sequence (I, -Qh), (-I, Qh), ... selected by a phase that flips on every
// transferred pair. The very first sample after reset only primes the
// holding register.
//
// Ports
//   i_clock                     rising-edge clock
//   i_reset_n                   asynchronous active-low reset
//   i_inph_data, i_quad_data    signed complex input sample
//   i_valid, o_ready            input handshake (o_ready is registered)
//   o_inph_data                 earlier real output sample of the pair
//   o_inph_delay_data           later real output sample of the pair
//   o_valid, i_ready            output handshake
module upconverter
  import upconverter_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic signed [WIDTH-1:0] i_inph_data,
  input  logic signed [WIDTH-1:0] i_quad_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic signed [WIDTH-1:0] o_inph_data,
  output logic signed [WIDTH-1:0] o_inph_delay_data,
  output logic                    o_valid,
  input  logic                    i_ready
);

  localparam logic signed [WIDTH-1:0] SatMax = WIDTH'(SAT_MAX(WIDTH));
  localparam logic signed [WIDTH-1:0] SatMin = WIDTH'(SAT_MIN(WIDTH));

  // ---------------------------------------------------------------------------
  // Input skid buffer
  // ---------------------------------------------------------------------------
  logic                    smp_valid;
  logic                    smp_ready;
  logic [2*WIDTH-1:0]      smp_data;
  logic signed [WIDTH-1:0] smp_i;
  logic signed [WIDTH-1:0] smp_q;

  upconverter_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk_i   (i_clock),
    .rst_ni  (i_reset_n),
    .valid_i (i_valid),
    .ready_o (o_ready),
    .data_i  ({i_inph_data, i_quad_data}),
    .valid_o (smp_valid),
    .ready_i (smp_ready),
    .data_o  (smp_data)
  );

  assign smp_i = smp_data[2*WIDTH-1:WIDTH];
  assign smp_q = smp_data[WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // Holding register for x[n].
  logic                    prev_valid_q, prev_valid_d;
  logic signed [WIDTH-1:0] prev_i_q, prev_i_d;
  logic signed [WIDTH-1:0] prev_q_q, prev_q_d;

  // Stage 1: I[n] and the interpolated half-sample.
  logic                    s1_valid_q, s1_valid_d;
  logic signed [WIDTH-1:0] s1_i_q, s1_i_d;
  logic signed [WIDTH-1:0] s1_ih_q, s1_ih_d;
  logic signed [WIDTH-1:0] s1_qh_q, s1_qh_d;

  // Stage 2: mixed output pair.
  logic                    s2_valid_q, s2_valid_d;
  logic signed [WIDTH-1:0] s2_a_q, s2_a_d;
  logic signed [WIDTH-1:0] s2_b_q, s2_b_d;

  // Phase of the pair currently at (or next to reach) the output.
  phase_e phase_q, phase_d;

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic s2_adv;
  logic s1_adv;
  logic take;
  logic pair_fire;
  logic out_fire;

  assign s2_adv    = ~s2_valid_q | i_ready;
  assign s1_adv    = ~s1_valid_q | s2_adv;
  // A primer never produces a pair, so it can be taken regardless of stalls.
  assign smp_ready = ~prev_valid_q | s1_adv;
  assign take      = smp_valid & smp_ready;
  assign pair_fire = take & prev_valid_q;
  assign out_fire  = s2_valid_q & i_ready;

  // ---------------------------------------------------------------------------
  // Interpolation: (a + b + 1) >>> 1 at WIDTH+1 bits, always fits in WIDTH.
  // ---------------------------------------------------------------------------
  logic signed [WIDTH:0] sum_i;
  logic signed [WIDTH:0] sum_q;
  logic                  unused_sum_lsb;

  assign sum_i = {prev_i_q[WIDTH-1], prev_i_q} + {smp_i[WIDTH-1], smp_i} + (WIDTH+1)'(1);
  assign sum_q = {prev_q_q[WIDTH-1], prev_q_q} + {smp_q[WIDTH-1], smp_q} + (WIDTH+1)'(1);
  assign unused_sum_lsb = sum_i[0] ^ sum_q[0];

  always_comb begin
    prev_valid_d = prev_valid_q;
    prev_i_d     = prev_i_q;
    prev_q_d     = prev_q_q;
    s1_valid_d   = s1_valid_q;
    s1_i_d       = s1_i_q;
    s1_ih_d      = s1_ih_q;
    s1_qh_d      = s1_qh_q;

    if (take) begin
      prev_valid_d = 1'b1;
      prev_i_d     = smp_i;
      prev_q_d     = smp_q;
    end

    if (s1_adv) begin
      s1_valid_d = pair_fire;
      if (pair_fire) begin
        s1_i_d  = prev_i_q;
        s1_ih_d = sum_i[WIDTH:1];
        s1_qh_d = sum_q[WIDTH:1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mixing with saturating negation
  // ---------------------------------------------------------------------------
  logic signed [WIDTH-1:0] neg_i;
  logic signed [WIDTH-1:0] neg_qh;
  phase_e                  load_phase;
  logic                    unused_ih;

  assign neg_i  = (s1_i_q  == SatMin) ? SatMax : -s1_i_q;
  assign neg_qh = (s1_qh_q == SatMin) ? SatMax : -s1_qh_q;
  // Ih is carried for completeness; at fs/4 the I-branch only needs I[n].
  assign unused_ih = ^s1_ih_q;

  // Stage 2 only loads while empty or while its current pair leaves, so the
  // incoming pair's phase is the current phase, advanced if a pair is leaving.
  always_comb begin
    load_phase = phase_q;
    if (s2_valid_q) begin
      load_phase = (phase_q == PH_POS_I) ? PH_NEG_I : PH_POS_I;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_a_d     = s2_a_q;
    s2_b_d     = s2_b_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        if (load_phase == PH_POS_I) begin
          s2_a_d = s1_i_q;
          s2_b_d = neg_qh;
        end else begin
          s2_a_d = neg_i;
          s2_b_d = s1_qh_q;
        end
      end
    end
  end

  always_comb begin
    phase_d = phase_q;
    if (out_fire) begin
      phase_d = (phase_q == PH_POS_I) ? PH_NEG_I : PH_POS_I;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      prev_valid_q <= 1'b0;
      prev_i_q     <= '0;
      prev_q_q     <= '0;
      s1_valid_q   <= 1'b0;
      s1_i_q       <= '0;
      s1_ih_q      <= '0;
      s1_qh_q      <= '0;
      s2_valid_q   <= 1'b0;
      s2_a_q       <= '0;
      s2_b_q       <= '0;
      phase_q      <= PH_POS_I;
    end else begin
      prev_valid_q <= prev_valid_d;
      prev_i_q     <= prev_i_d;
      prev_q_q     <= prev_q_d;
      s1_valid_q   <= s1_valid_d;
      s1_i_q       <= s1_i_d;
      s1_ih_q      <= s1_ih_d;
      s1_qh_q      <= s1_qh_d;
      s2_valid_q   <= s2_valid_d;
      s2_a_q       <= s2_a_d;
      s2_b_q       <= s2_b_d;
      phase_q      <= phase_d;
    end
  end

  assign o_valid           = s2_valid_q;
  assign o_inph_data       = s2_a_q;
  assign o_inph_delay_data = s2_b_q;

endmodule

// File: doc/upconverter.md
UPCONVERTER -- requirements
Module: upconverter

Interface
REQ-001 Parameter: WIDTH, default 16, signed sample width of all data ports.
REQ-002 Ports: i_clock  in  1  sole clock, rising-edge.
REQ-003 Ports: i_reset_n  in  1  reset, asynchronous, active-low.
REQ-004 Ports: i_inph_data, i_quad_data  in  WIDTH each  complex baseband sample I/Q, signed.
REQ-005 Ports: i_valid  in  1 / o_ready  out  1  input handshake; transfer when both high on a rising edge.
REQ-006 Ports: o_inph_data  out  WIDTH  earlier real output sample of the pair, signed.
REQ-007 Ports: o_inph_delay_data  out  WIDTH  later real output sample of the pair, signed.
REQ-008 Ports: o_valid  out  1 / i_ready  in  1  output handshake; pair transfers when both high.

Function
REQ-009 Block SHALL interpolate by 2 and mix to fs/4 at the output rate; each accepted complex sample yields one real output pair.
REQ-010 Interpolation: for accepted x[n] and successor x[n+1], Ih=(I[n]+I[n+1]+1)>>>1 and Qh=(Q[n]+Q[n+1]+1)>>>1, computed at WIDTH+1 bits; result fits WIDTH without saturation.
REQ-011 Pair n SHALL be computed only after x[n+1] is accepted; first sample after reset only primes the holding register and emits nothing.
REQ-012 Mixing uses 1-bit pair toggle T: T=0 -> (o_inph_data, o_inph_delay_data)=(I[n], sat(-Qh)); T=1 -> (sat(-I[n]), Qh).
REQ-013 sat(-v) SHALL map -2^(WIDTH-1) to 2^(WIDTH-1)-1; all other negations exact.
REQ-014 T SHALL reset to 0 and flip once per output pair transferred (o_valid and i_ready high).
REQ-015 Latency: o_valid for pair n SHALL assert exactly 2 cycles after the edge accepting x[n+1], given i_ready held high.
REQ-016 Stages: stage 1 registers I[n], Ih, Qh; stage 2 registers negation/saturation; pipeline advances only when stage 2 is empty or i_ready high.
REQ-017 o_ready SHALL be a registered signal driven by a 2-entry skid buffer; a sample presented while o_ready high is never dropped.
REQ-018 With i_ready low, o_valid and both output data SHALL hold stable until transfer.
REQ-019 Simultaneous accept at input and transfer at output in one cycle SHALL sustain one pair per cycle with no bubble.
REQ-020 i_valid gaps SHALL NOT break interpolation continuity; x[n+1] pairs with last held x[n] regardless of gap length.
REQ-021 Outputs with o_valid low are don't-care but SHALL not toggle X after reset.

Reset
REQ-022 On i_reset_n low all state SHALL clear asynchronously: o_valid=0, o_ready=0, outputs=0, T=0, holding register empty, skid buffer empty.
REQ-023 o_ready SHALL rise on the first rising edge after reset deassertion.
REQ-024 Reset mid-operation SHALL discard in-flight and held samples; next accepted sample is again a primer only.

Structure
REQ-025 Package upconverter_pkg SHALL hold saturation constants (SAT_MAX, SAT_MIN as WIDTH functions) and the toggle phase enum {PH_POS_I, PH_NEG_I}.
REQ-026 Skid buffer SHALL be sub-module upconverter_skid (parameter WIDTH for payload 2*WIDTH); all other logic stays in upconverter.

Verification
REQ-027 Reset, then x=(100,200),(300,400) with i_ready=1 -> one pair (100,-300), o_valid 2 cycles after second accept.
REQ-028 Constant x=(1000,-500) streamed 5 samples -> pairs alternate (1000,500),(-1000,-500), 4 pairs, no bubbles.
REQ-029 x=(-32768,-32768),(-32768,-32768) -> pair (-32768,32767); next pair T=1 -> (32767,-32768).
REQ-030 Rounding: I=(1,2) and Q=(-1,-2) -> Ih=2, Qh=-1; pair (1,1).
REQ-031 Random i_valid and i_ready (50% each), 1000 samples -> output matches reference model, no loss/duplication, outputs stable while stalled.
REQ-032 Assert i_reset_n low with pairs in flight -> o_valid=0 immediately; after release first accepted sample produces no output.
